// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the multi-channel serial pattern detector.
// Used by the top level and by the per-channel sub-module.
package seq_det_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        ARMED = 2'd2,
        DONE  = 2'd3
    } chan_state_e;

    typedef enum logic [1:0] {
        STICKY  = 2'd0,
        OVERLAP = 2'd1,
        NONOVL  = 2'd2,
        RSVD    = 2'd3
    } det_mode_e;

    // A zero-length pattern is meaningless, so it is promoted to one bit.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        if (len == 0)
            return 1;
        else if (len > max_len)
            return max_len;
        return len;
    endfunction

endpackage

// File: rtl/seq_det_chan.sv
// One detector channel: shift register, fill count, match FSM,
// registered match flag and saturating hit counter.
module seq_det_chan
    import seq_det_pkg::*;
#(
    parameter int PAT_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LW      = $clog2(PAT_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               state_reset,
    input  logic               valid,
    input  logic               data,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic [PAT_LEN-1:0] mask,
    input  logic [LW-1:0]      len,
    input  det_mode_e          mode,
    output chan_state_e        state,
    output logic               out,
    output logic [CNT_W-1:0]   hit_cnt
);

    chan_state_e        state_q, state_n;
    logic [PAT_LEN-1:0] sr_q, sr_n;
    logic [LW-1:0]      fill_q, fill_n;
    logic               out_q, out_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;

    logic [PAT_LEN-1:0] sr_shift;
    logic [LW-1:0]      fill_inc;
    logic               match;

    assign sr_shift = {sr_q[PAT_LEN-2:0], data};
    assign fill_inc = (fill_q < len) ? fill_q + LW'(1) : len;
    assign match    = (fill_inc == len) && (((sr_shift ^ pattern) & mask) == '0);

    always_comb begin
        // NOTE: every next-state variable takes its hold value first, so no
        // path through the branches below can leave one unassigned (no latch).
        state_n = state_q;
        sr_n    = sr_q;
        fill_n  = fill_q;
        out_n   = (state_q == DONE);
        cnt_n   = cnt_q;

        if (clear || state_reset) begin
            state_n = IDLE;
            sr_n    = '0;
            fill_n  = '0;
            out_n   = 1'b0;
            cnt_n   = '0;
        end else if (valid && state_q != DONE) begin
            sr_n   = sr_shift;
            fill_n = fill_inc;
            if (match) begin
                out_n = 1'b1;
                if (cnt_q != '1)
                    cnt_n = cnt_q + CNT_W'(1);
                unique case (mode)
                    OVERLAP: state_n = ARMED;
                    NONOVL: begin
                        state_n = IDLE;
                        sr_n    = '0;
                        fill_n  = '0;
                    end
                    default: state_n = DONE;
                endcase
            end else begin
                state_n = (fill_inc == len) ? ARMED : FILL;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values; the shift register is reset too, since a
    // stale history could otherwise complete a match right after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            fill_q  <= '0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            sr_q    <= sr_n;
            fill_q  <= fill_n;
            out_q   <= out_n;
            cnt_q   <= cnt_n;
        end
    end

    assign state   = state_q;
    assign out     = out_q;
    assign hit_cnt = cnt_q;

endmodule

// File: rtl/seq_det_mc.sv
// Multi-channel serial pattern detector: shadow configuration register,
// pattern mask generation and CH independent detector channels.
module seq_det_mc
    import seq_det_pkg::*;
#(
    parameter  int CH      = 4,
    parameter  int PAT_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LW      = $clog2(PAT_LEN + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_load,
    input  logic [PAT_LEN-1:0]  cfg_pattern,
    input  logic [LW-1:0]       cfg_len,
    input  logic [1:0]          cfg_mode,
    input  logic [CH-1:0]       in_valid,
    input  logic [CH-1:0]       in_data,
    input  logic [CH-1:0]       in_state_reset,
    output logic [2*CH-1:0]     out_cur_state,
    output logic [CH-1:0]       out,
    output logic [CNT_W*CH-1:0] hit_cnt
);

    logic [PAT_LEN-1:0] pat_q;
    logic [LW-1:0]      len_q;
    det_mode_e          mode_q;
    logic [PAT_LEN-1:0] mask;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q  <= '0;
            len_q  <= LW'(PAT_LEN);
            mode_q <= STICKY;
        end else if (cfg_load) begin
            pat_q  <= cfg_pattern;
            len_q  <= LW'(clamp_len(32'(cfg_len), PAT_LEN));
            mode_q <= det_mode_e'(cfg_mode);
        end
    end

    // Only the low len_q bits of history take part in the comparison.
    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_LEN; i++)
            mask[i] = (i < int'(len_q));
    end

    chan_state_e ch_state [CH];

    for (genvar c = 0; c < CH; c++) begin : g_chan
        seq_det_chan #(
            .PAT_LEN (PAT_LEN),
            .CNT_W   (CNT_W),
            .LW      (LW)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .clear       (cfg_load),
            .state_reset (in_state_reset[c]),
            .valid       (in_valid[c]),
            .data        (in_data[c]),
            .pattern     (pat_q),
            .mask        (mask),
            .len         (len_q),
            .mode        (mode_q),
            .state       (ch_state[c]),
            .out         (out[c]),
            .hit_cnt     (hit_cnt[CNT_W*c +: CNT_W])
        );

        assign out_cur_state[2*c +: 2] = ch_state[c];
    end

endmodule

// File: tb/tb_seq_det_mc.sv
// Directed bench for seq_det_mc with hand-computed expected values.
module tb_seq_det_mc;

    localparam int CH      = 4;
    localparam int PAT_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LW      = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                cfg_load;
    logic [PAT_LEN-1:0]  cfg_pattern;
    logic [LW-1:0]       cfg_len;
    logic [1:0]          cfg_mode;
    logic [CH-1:0]       in_valid;
    logic [CH-1:0]       in_data;
    logic [CH-1:0]       in_state_reset;
    logic [2*CH-1:0]     out_cur_state;
    logic [CH-1:0]       out;
    logic [CNT_W*CH-1:0] hit_cnt;

    int n_checks = 0;
    int n_errors = 0;

    seq_det_mc #(
        .CH      (CH),
        .PAT_LEN (PAT_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_load       (cfg_load),
        .cfg_pattern    (cfg_pattern),
        .cfg_len        (cfg_len),
        .cfg_mode       (cfg_mode),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_state_reset (in_state_reset),
        .out_cur_state  (out_cur_state),
        .out            (out),
        .hit_cnt        (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] st(input int c);
        return 32'(out_cur_state[2*c +: 2]);
    endfunction

    function automatic logic [31:0] cnt(input int c);
        return 32'(hit_cnt[CNT_W*c +: CNT_W]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [CH-1:0] v, input logic [CH-1:0] d, input logic [CH-1:0] sres);
        in_valid       = v;
        in_data        = d;
        in_state_reset = sres;
        tick();
        in_valid       = '0;
        in_data        = '0;
        in_state_reset = '0;
    endtask

    task automatic send(input int c, input logic b);
        logic [CH-1:0] m;
        m    = '0;
        m[c] = 1'b1;
        drive(m, b ? m : '0, '0);
    endtask

    task automatic load(input logic [PAT_LEN-1:0] pat, input logic [LW-1:0] len, input logic [1:0] mode);
        cfg_load    = 1'b1;
        cfg_pattern = pat;
        cfg_len     = len;
        cfg_mode    = mode;
        tick();
        cfg_load    = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        cfg_load       = 1'b0;
        cfg_pattern    = '0;
        cfg_len        = '0;
        cfg_mode       = '0;
        in_valid       = '0;
        in_data        = '0;
        in_state_reset = '0;
        #12;
        check("rst_out", 32'(out), 0);
        check("rst_cnt", 32'(hit_cnt), 0);
        check("rst_state", 32'(out_cur_state), 0);
        rst = 1'b0;
        tick();

        // Sticky: pattern 1011, stream oldest-first 1,0,1,1
        load(8'h0B, 4'd4, 2'd0);
        send(0, 1'b1); send(0, 1'b0); send(0, 1'b1);
        check("stk_fill_state", st(0), 1);
        check("stk_fill_out", 32'(out[0]), 0);
        send(0, 1'b1);
        check("stk_out", 32'(out[0]), 1);
        check("stk_state", st(0), 3);
        check("stk_cnt", cnt(0), 1);
        send(0, 1'b0); send(0, 1'b1);
        check("stk_hold_out", 32'(out[0]), 1);
        check("stk_hold_cnt", cnt(0), 1);
        check("stk_hold_state", st(0), 3);

        // Overlap: pattern 101, stream 1,0,1,0,1
        load(8'h05, 4'd3, 2'd1);
        check("load_clr_cnt", cnt(0), 0);
        check("load_clr_state", st(0), 0);
        check("load_clr_out", 32'(out[0]), 0);
        send(1, 1'b1); send(1, 1'b0); send(1, 1'b1);
        check("ovl_out1", 32'(out[1]), 1);
        check("ovl_cnt1", cnt(1), 1);
        check("ovl_armed", st(1), 2);
        send(1, 1'b0);
        check("ovl_out_low", 32'(out[1]), 0);
        send(1, 1'b1);
        check("ovl_out2", 32'(out[1]), 1);
        check("ovl_cnt2", cnt(1), 2);
        tick();
        check("ovl_idle_drop", 32'(out[1]), 0);
        check("ovl_idle_cnt", cnt(1), 2);

        // Non-overlap: same pattern and stream
        load(8'h05, 4'd3, 2'd2);
        check("nov_clr_cnt", cnt(1), 0);
        send(1, 1'b1); send(1, 1'b0); send(1, 1'b1);
        check("nov_out1", 32'(out[1]), 1);
        check("nov_cnt1", cnt(1), 1);
        check("nov_idle", st(1), 0);
        send(1, 1'b0);
        check("nov_out_low", 32'(out[1]), 0);
        check("nov_fill1", st(1), 1);
        send(1, 1'b1);
        check("nov_no_second", 32'(out[1]), 0);
        check("nov_cnt_end", cnt(1), 1);
        check("nov_fill2", st(1), 1);

        // Valid gaps between bits 2 and 3
        load(8'h0B, 4'd4, 2'd0);
        send(0, 1'b1); send(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("gap_out_%0d", i), 32'(out[0]), 0);
            check($sformatf("gap_state_%0d", i), st(0), 1);
        end
        send(0, 1'b1);
        check("gap_bit3_out", 32'(out[0]), 0);
        send(0, 1'b1);
        check("gap_match_out", 32'(out[0]), 1);
        check("gap_match_cnt", cnt(0), 1);

        // in_state_reset collides with the completing bit on ch2; ch0 runs alongside
        load(8'h0B, 4'd4, 2'd0);
        drive(4'b0101, 4'b0101, 4'b0000);
        drive(4'b0101, 4'b0000, 4'b0000);
        drive(4'b0101, 4'b0101, 4'b0000);
        drive(4'b0101, 4'b0101, 4'b0100);
        check("col_out2", 32'(out[2]), 0);
        check("col_state2", st(2), 0);
        check("col_cnt2", cnt(2), 0);
        check("col_out0", 32'(out[0]), 1);
        check("col_state0", st(0), 3);
        check("col_cnt0", cnt(0), 1);
        check("col_state1", st(1), 0);

        // cfg_len 0 stored as 1, overlap, counter saturates at 3
        load(8'h01, 4'd0, 2'd1);
        for (int i = 0; i < 6; i++) begin
            send(3, 1'b1);
            check($sformatf("sat_out_%0d", i), 32'(out[3]), 1);
            check($sformatf("sat_cnt_%0d", i), cnt(3), (i < 3) ? i + 1 : 3);
        end
        check("sat_state", st(3), 2);
        send(3, 1'b0);
        check("sat_zero_out", 32'(out[3]), 0);
        check("sat_zero_cnt", cnt(3), 3);

        // cfg_len 15 clamped to 8
        load(8'hFF, 4'd15, 2'd1);
        repeat (7) send(2, 1'b1);
        check("clamp_fill", st(2), 1);
        check("clamp_no_match", 32'(out[2]), 0);
        send(2, 1'b1);
        check("clamp_match", 32'(out[2]), 1);
        check("clamp_armed", st(2), 2);

        // Async reset mid-cycle while ch0 sits in DONE
        load(8'h0B, 4'd4, 2'd0);
        send(0, 1'b1); send(0, 1'b0); send(0, 1'b1); send(0, 1'b1);
        check("arst_pre_out", 32'(out[0]), 1);
        #3 rst = 1'b1;
        #1;
        check("arst_out", 32'(out), 0);
        check("arst_cnt", 32'(hit_cnt), 0);
        check("arst_state", 32'(out_cur_state), 0);
        #2 rst = 1'b0;
        // Default config: pattern 0, len 8, sticky
        repeat (7) send(0, 1'b0);
        check("dflt_fill", st(0), 1);
        check("dflt_no_match", 32'(out[0]), 0);
        send(0, 1'b0);
        check("dflt_match", 32'(out[0]), 1);
        check("dflt_sticky", st(0), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
